// File: rtl/eth_tx_arbiter_if.sv
// Stream bundle between the three frame generators, the TX arbiter and the RGMII TX MAC.
// master is the arbiter side; slave is the generators plus MAC side.
interface eth_tx_arbiter_if;
  logic [23:0] S_TDATA;
  logic [2:0]  S_TVALID;
  logic [2:0]  S_TLAST;
  logic [2:0]  S_TREADY;
  logic [7:0]  RGMII_TX_DATA;
  logic        RGMII_TX_VALID;
  logic        RGMII_TX_LAST;
  logic        RGMII_TX_READY;

  modport master (
    input  S_TDATA, S_TVALID, S_TLAST, RGMII_TX_READY,
    output S_TREADY, RGMII_TX_DATA, RGMII_TX_VALID, RGMII_TX_LAST
  );

  modport slave (
    output S_TDATA, S_TVALID, S_TLAST, RGMII_TX_READY,
    input  S_TREADY, RGMII_TX_DATA, RGMII_TX_VALID, RGMII_TX_LAST
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Fixed-priority arbiter sharing the RGMII TX stream between the ARP, ICMP and UDP generators.
// It enforces an inter-frame gap and abandons frames that stall in transfer.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK_125M,
  input  logic              SYS_RST_N,
  input  logic [2:0]        REQ,
  eth_tx_arbiter_if.master  bus,
  output logic [2:0]        GRANT,
  output logic [2:0]        PENDING,
  output logic              BUSY,
  output logic              TIMEOUT_ERR
);

  localparam int unsigned IFG_EFF = (IFG_CYCLES == 0) ? 1 : IFG_CYCLES;
  localparam int unsigned IFG_W   = (IFG_EFF < 2) ? 1 : $clog2(IFG_CYCLES + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_IFG  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       grant_d, pending_d, clr_c;
  logic             busy_d, timeout_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic             beat_c;

  // Zero-latency mux: only the selected source reaches the MAC, and only while transferring.
  always_comb begin
    bus.RGMII_TX_DATA  = 8'h00;
    bus.RGMII_TX_VALID = 1'b0;
    bus.RGMII_TX_LAST  = 1'b0;
    bus.S_TREADY       = 3'b000;
    if (state_q == ST_XFER) begin
      case (sel_q)
        2'd1: begin
          bus.RGMII_TX_DATA  = bus.S_TDATA[15:8];
          bus.RGMII_TX_VALID = bus.S_TVALID[1];
          bus.RGMII_TX_LAST  = bus.S_TLAST[1];
          bus.S_TREADY       = {1'b0, bus.RGMII_TX_READY, 1'b0};
        end
        2'd2: begin
          bus.RGMII_TX_DATA  = bus.S_TDATA[23:16];
          bus.RGMII_TX_VALID = bus.S_TVALID[2];
          bus.RGMII_TX_LAST  = bus.S_TLAST[2];
          bus.S_TREADY       = {bus.RGMII_TX_READY, 2'b00};
        end
        default: begin
          bus.RGMII_TX_DATA  = bus.S_TDATA[7:0];
          bus.RGMII_TX_VALID = bus.S_TVALID[0];
          bus.RGMII_TX_LAST  = bus.S_TLAST[0];
          bus.S_TREADY       = {2'b00, bus.RGMII_TX_READY};
        end
      endcase
    end
  end

  assign beat_c = bus.RGMII_TX_VALID & bus.RGMII_TX_READY;

  // Next-state, grant, watchdog and gap counter.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = GRANT;
    clr_c     = 3'b000;
    wd_d      = wd_q;
    ifg_d     = ifg_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PENDING != 3'b000) begin
          if (PENDING[0])      sel_d = 2'd0;
          else if (PENDING[1]) sel_d = 2'd1;
          else                 sel_d = 2'd2;
          grant_d = 3'(3'b001 << sel_d);
          clr_c   = grant_d;
          wd_d    = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_c && bus.RGMII_TX_LAST) begin
          grant_d = 3'b000;
          ifg_d   = '0;
          state_d = ST_IFG;
        end else if (beat_c) begin
          wd_d = '0;
        end else if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled frame is dropped as-is; the MAC never sees a synthesized LAST.
          wd_d      = WD_W'(TIMEOUT_CYCLES);
          timeout_d = 1'b1;
          grant_d   = 3'b000;
          ifg_d     = '0;
          state_d   = ST_IFG;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_IFG: begin
        if (ifg_q == IFG_W'(IFG_EFF - 1)) state_d = ST_IDLE;
        else                              ifg_d   = ifg_q + IFG_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // A new request on the grant edge re-arms the bit, so the source is served again.
    pending_d = (PENDING & ~clr_c) | REQ;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      GRANT       <= 3'b000;
      PENDING     <= 3'b000;
      BUSY        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      wd_q        <= '0;
      ifg_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      GRANT       <= grant_d;
      PENDING     <= pending_d;
      BUSY        <= busy_d;
      TIMEOUT_ERR <= timeout_d;
      wd_q        <= wd_d;
      ifg_q       <= ifg_d;
    end
  end

endmodule
